// File: rtl/mux_scan_ctrl.sv
// Sequencer for an 8:1 mux stage: loads a byte onto the mux inputs, walks the select
// 0..7 with DIV settle cycles per slot, and rebuilds the byte from the mux output.
// Optional compare logic (mismatch, err_sticky) is built when MUX_SCAN_CHECK_EN is defined.
module mux_scan_ctrl #(
    parameter int unsigned DIV = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] mux_i,
    output logic [2:0] mux_s,
    input  logic       mux_f,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
`ifdef MUX_SCAN_CHECK_EN
    ,
    output logic       mismatch,
    output logic       err_sticky
`endif
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned SEL_W  = 3;
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(DATA_W - 1);

    if (DIV == 0 || DIV > 255) begin : g_div_illegal
        $error("mux_scan_ctrl: DIV must be in 1..255");
    end

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [DATA_W-1:0]  cap, cap_nxt;
    logic [DATA_W-1:0]  mux_i_nxt, out_data_nxt;
    logic [SEL_W-1:0]   mux_s_nxt;
    logic               out_valid_nxt, busy_nxt;
    logic [DATA_W-1:0]  rebuilt_c;
`ifdef MUX_SCAN_CHECK_EN
    logic               mismatch_nxt, err_sticky_nxt;
`endif

    // Acceptance is decoded straight from state so it reads high during reset.
    assign in_ready  = (state == IDLE);
    assign rebuilt_c = {mux_f, cap[DATA_W-2:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        cap_nxt       = cap;
        mux_i_nxt     = mux_i;
        mux_s_nxt     = mux_s;
        out_data_nxt  = out_data;
        out_valid_nxt = out_valid;
`ifdef MUX_SCAN_CHECK_EN
        mismatch_nxt  = mismatch;
`endif
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = SCAN;
                    mux_i_nxt = in_data;
                    mux_s_nxt = '0;
                    cnt_nxt   = CNT_RELOAD;
                    cap_nxt   = '0;
                end
            end
            SCAN: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    cap_nxt[mux_s] = mux_f;
                    if (mux_s != LAST_SEL) begin
                        mux_s_nxt = mux_s + SEL_W'(1);
                        cnt_nxt   = CNT_RELOAD;
                    end else begin
                        // Last slot: bit 7 comes straight from the mux, not from cap.
                        out_data_nxt  = rebuilt_c;
                        out_valid_nxt = 1'b1;
                        state_nxt     = HOLD;
`ifdef MUX_SCAN_CHECK_EN
                        mismatch_nxt  = (rebuilt_c != mux_i);
`endif
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
`ifdef MUX_SCAN_CHECK_EN
                    mismatch_nxt  = 1'b0;
`endif
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        busy_nxt = (state_nxt != IDLE);
`ifdef MUX_SCAN_CHECK_EN
        err_sticky_nxt = err_sticky | mismatch_nxt;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            cap        <= '0;
            mux_i      <= '0;
            mux_s      <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
`ifdef MUX_SCAN_CHECK_EN
            mismatch   <= 1'b0;
            err_sticky <= 1'b0;
`endif
        end else begin
            cnt        <= cnt_nxt;
            cap        <= cap_nxt;
            mux_i      <= mux_i_nxt;
            mux_s      <= mux_s_nxt;
            out_data   <= out_data_nxt;
            out_valid  <= out_valid_nxt;
            busy       <= busy_nxt;
`ifdef MUX_SCAN_CHECK_EN
            mismatch   <= mismatch_nxt;
            err_sticky <= err_sticky_nxt;
`endif
        end
    end

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

- Sequencer that drives the 8:1 mux select stage directly downstream of it.
- Accepts a byte on a valid/ready handshake and drives it onto the mux data inputs.
- Steps the mux select through 0..7, samples the mux output once per slot and rebuilds the byte.
- Presents the rebuilt byte on an output handshake, so the mux datapath can be exercised and checked end to end.

## Interface
- DIV, 1, settle cycles per select slot; legal range 1..255; DIV=0 is illegal (elaboration error)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_data  in  8  byte to scan
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept; high only in IDLE
- mux_i  out  8  to mux I[7:0]
- mux_s  out  3  to mux S; value k selects I[k]
- mux_f  in  1  from mux F
- out_data  out  8  rebuilt byte; bit k = mux_f sampled while mux_s==k
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- busy  out  1  high in SCAN or HOLD

## Operation
- States:
  - IDLE: in_ready=1.
  - SCAN: in_ready=0.
  - HOLD: out_valid=1.
- IDLE -> SCAN on in_valid&in_ready at a clock edge. On that edge:
  - mux_i<=in_data.
  - mux_s<=0.
  - Slot counter cnt<=DIV-1.
  - Capture register cap<=0.
- SCAN, cnt!=0: cnt decrements; mux_i and mux_s hold.
- SCAN, cnt==0:
  - cap[mux_s]<=mux_f.
  - If mux_s!=7: mux_s<=mux_s+1 and cnt<=DIV-1.
  - If mux_s==7: out_data<=cap with bit 7 replaced by mux_f; out_valid<=1; go to HOLD.
- mux_s never wraps within a scan; it stays at 7 in HOLD and returns to 0 only on the next accept.
- HOLD: out_data and out_valid are stable until out_valid&out_ready at an edge. On that edge out_valid<=0 and the state goes to IDLE.
- in_valid is ignored outside IDLE; no input buffering.
- mux_i holds the last accepted byte until the next accept or reset.
- Reset (rst_n low, any state, mid-scan included) forces immediately and asynchronously:
  - State IDLE.
  - mux_i=0, mux_s=0, cnt=0, cap=0, out_data=0, out_valid=0, busy=0.
  - Any partial scan is discarded.
  - in_ready is decoded from state, so it reads 1 during reset; transfers while rst_n is low are ignored.

## Timing
- Accept at edge T0. Bit k is sampled at edge T0+(k+1)*DIV.
- out_valid rises at edge T0+8*DIV. Latency is 8*DIV cycles.
- With out_ready held high:
  - Return to IDLE at edge T0+8*DIV+1.
  - Earliest next accept at edge T0+8*DIV+2.
  - Throughput is one byte per 8*DIV+2 cycles.
- mux_f is sampled DIV cycles after each mux_s change. The mux stage is combinational and must settle within DIV cycles.
- All outputs except in_ready are registered.
- busy = (state!=IDLE), registered with state.

## Configuration
- Macro MUX_SCAN_CHECK_EN.
- Defined: the block adds outputs mismatch (1) and err_sticky (1), both reset to 0.
  - On the edge that raises out_valid, mismatch<=(rebuilt byte != mux_i). mismatch holds through HOLD and clears on the out handshake.
  - err_sticky sets with mismatch and clears only on reset.
- Undefined: neither port exists and no compare logic is built. All other behaviour is identical.

## Test plan
- Reset mid-scan:
  - DIV=1; accept 8'hA5; assert rst_n=0 at T0+3.
  - Required: mux_s, mux_i, out_valid and cap read 0 immediately.
  - Required: after release, in_ready=1 and no out_valid appears.
- Basic scan:
  - DIV=1; accept 8'h42 with an ideal mux model.
  - Required: mux_s steps 0..7 on consecutive cycles; out_valid at T0+8; out_data=8'h42.
- Slow settle:
  - DIV=3; accept 8'hAA.
  - Required: each mux_s value held 3 cycles; out_valid at T0+24; out_data=8'hAA.
- Backpressure:
  - out_ready=0 for 5 cycles after out_valid; in_valid held high with 8'h0F.
  - Required: out_data is stable and in_ready=0 throughout; 8'h0F is accepted 1 cycle after the out handshake.
- Check feature (MUX_SCAN_CHECK_EN):
  - Mux model that always returns I[0]; accept 8'h00, then 8'hFF, then 8'h02.
  - Required: mismatch=0 for 8'h00 and 8'hFF.
  - Required: mismatch=1 for 8'h02 (out_data=8'h00); err_sticky stays 1 until reset.
